// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory access arbiter.
// State and grant encodings are fixed so waveforms read the same in every block.
package mem_access_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } state_t;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } gnt_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the IFU, LSU and memory handshake signals seen by the arbiter.
// slave is the arbiter's view; master is the view of the requesters plus memory.
interface mem_access_arbiter_if;
   import mem_access_arbiter_pkg::*;

   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_rsp_valid;
   logic [DATA_W-1:0] ifu_rdata;
   logic              ifu_rsp_err;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic              lsu_we;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_wdata;
   logic [MASK_W-1:0] lsu_wmask;
   logic              lsu_rsp_valid;
   logic [DATA_W-1:0] lsu_rdata;
   logic              lsu_rsp_err;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
      input  lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
      output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
      output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rdata
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
      output lsu_req_valid, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
      input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rdata
   );

endinterface

// File: rtl/mem_access_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin picker: one-hot grant indexed by gnt_t.
// The pointer names the requester that wins when both are valid.
module rr_arbiter_2
   import mem_access_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  gnt_t       ptr,
   output logic [1:0] gnt
);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = 2'b00;
      if (req[GNT_IFU] && (!req[GNT_LSU] || ptr == GNT_IFU)) begin
         gnt[GNT_IFU] = 1'b1;
      end else if (req[GNT_LSU]) begin
         gnt[GNT_LSU] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between IFU and LSU: round-robin accept, one
// outstanding transaction, registered response pulse or timeout error.
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst,
   mem_access_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state, next_state;
   gnt_t              rr_ptr;
   gnt_t              gnt_id;
   mem_req_t          hold;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        req_vec;
   logic [1:0]        gnt_vec;
   logic              accept;
   logic              rsp_ok;
   logic              rsp_tmo;
   logic [DATA_W-1:0] rsp_rdata;

   assign req_vec = {bus.lsu_req_valid, bus.ifu_req_valid};

   rr_arbiter_2 u_rr (
      .req (req_vec),
      .ptr (rr_ptr),
      .gnt (gnt_vec)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state        = state;
      bus.ifu_req_ready = 1'b0;
      bus.lsu_req_ready = 1'b0;
      bus.mem_req_valid = 1'b0;
      accept            = 1'b0;
      rsp_ok            = 1'b0;
      rsp_tmo           = 1'b0;
      case (state)
         IDLE: begin
            // Ready is masked during reset so every output reads 0 while rst is high.
            bus.ifu_req_ready = gnt_vec[GNT_IFU] & ~rst;
            bus.lsu_req_ready = gnt_vec[GNT_LSU] & ~rst;
            accept            = |gnt_vec;
            if (accept) next_state = REQ;
         end
         REQ: begin
            bus.mem_req_valid = 1'b1;
            if (cnt == CNT_LAST) begin
               rsp_tmo    = 1'b1;
               next_state = IDLE;
            end else if (bus.mem_req_ready) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            // A response in the timeout cycle still wins.
            if (bus.mem_rsp_valid) begin
               rsp_ok     = 1'b1;
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               rsp_tmo    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign rsp_rdata = (rsp_ok && !hold.we) ? bus.mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr            <= GNT_LSU;
         gnt_id            <= GNT_IFU;
         hold              <= '0;
         cnt               <= '0;
         bus.ifu_rsp_valid <= 1'b0;
         bus.ifu_rdata     <= '0;
         bus.ifu_rsp_err   <= 1'b0;
         bus.lsu_rsp_valid <= 1'b0;
         bus.lsu_rdata     <= '0;
         bus.lsu_rsp_err   <= 1'b0;
      end else begin
         bus.ifu_rsp_valid <= 1'b0;
         bus.lsu_rsp_valid <= 1'b0;

         if (accept) begin
            // gnt_t encodes LSU as 1, so the LSU grant bit is the grant id.
            gnt_id <= gnt_t'(gnt_vec[GNT_LSU]);
            rr_ptr <= gnt_t'(~gnt_vec[GNT_LSU]);
            cnt    <= '0;
            if (gnt_vec[GNT_LSU]) begin
               hold <= '{we: bus.lsu_we, addr: bus.lsu_addr,
                         wdata: bus.lsu_wdata, wmask: bus.lsu_wmask};
            end else begin
               hold <= '{we: 1'b0, addr: bus.ifu_addr, wdata: '0, wmask: '0};
            end
         end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
         end

         if (rsp_ok || rsp_tmo) begin
            if (gnt_id == GNT_LSU) begin
               bus.lsu_rsp_valid <= 1'b1;
               bus.lsu_rdata     <= rsp_rdata;
               bus.lsu_rsp_err   <= rsp_tmo;
            end else begin
               bus.ifu_rsp_valid <= 1'b1;
               bus.ifu_rdata     <= rsp_rdata;
               bus.ifu_rsp_err   <= rsp_tmo;
            end
         end
      end
   end

   assign bus.mem_we    = hold.we;
   assign bus.mem_addr  = hold.addr;
   assign bus.mem_wdata = hold.wdata;
   assign bus.mem_wmask = hold.wmask;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: main instance with TIMEOUT=8, and a
// second instance with TIMEOUT=4 for the response-versus-timeout race.
module tb_mem_access_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_access_arbiter_if bus8();
   mem_access_arbiter_if bus4();

   mem_access_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   mem_access_arbiter #(.TIMEOUT(4), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus8.ifu_req_valid = 1'b0; bus8.ifu_addr  = '0;
      bus8.lsu_req_valid = 1'b0; bus8.lsu_we    = 1'b0;
      bus8.lsu_addr      = '0;   bus8.lsu_wdata = '0; bus8.lsu_wmask = '0;
      bus8.mem_req_ready = 1'b0; bus8.mem_rsp_valid = 1'b0; bus8.mem_rdata = '0;
      bus4.ifu_req_valid = 1'b0; bus4.ifu_addr  = '0;
      bus4.lsu_req_valid = 1'b0; bus4.lsu_we    = 1'b0;
      bus4.lsu_addr      = '0;   bus4.lsu_wdata = '0; bus4.lsu_wmask = '0;
      bus4.mem_req_ready = 1'b0; bus4.mem_rsp_valid = 1'b0; bus4.mem_rdata = '0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      bus8.lsu_req_valid = 1'b1;
      #3;
      checks++;
      if ({bus8.mem_req_valid, bus8.mem_we, bus8.mem_wmask, bus8.ifu_req_ready, bus8.lsu_req_ready,
           bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.lsu_rsp_err} !== 12'h000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 0", {bus8.mem_req_valid, bus8.mem_we, bus8.mem_wmask,
                  bus8.ifu_req_ready, bus8.lsu_req_ready, bus8.ifu_rsp_valid, bus8.ifu_rsp_err,
                  bus8.lsu_rsp_valid, bus8.lsu_rsp_err});
      end
      checks++;
      if ({bus8.mem_addr, bus8.mem_wdata, bus8.ifu_rdata, bus8.lsu_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h %h expected 0", bus8.mem_addr, bus8.mem_wdata,
                  bus8.ifu_rdata, bus8.lsu_rdata);
      end
      checks++;
      if ({bus4.mem_req_valid, bus4.ifu_rsp_valid, bus4.lsu_rsp_valid, bus4.mem_addr} !== 35'h0) begin
         errors++;
         $display("FAIL reset_dut4: got %b %b %b %h expected 0", bus4.mem_req_valid,
                  bus4.ifu_rsp_valid, bus4.lsu_rsp_valid, bus4.mem_addr);
      end
      bus8.lsu_req_valid = 1'b0;
      do_reset();
   endtask

   task automatic test_ifu_read;
      bus8.ifu_req_valid = 1'b1;
      bus8.ifu_addr      = 32'h8000_0010;
      #1;
      checks++;
      if ({bus8.ifu_req_ready, bus8.lsu_req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL ifu_ready: got %b expected 10", {bus8.ifu_req_ready, bus8.lsu_req_ready});
      end
      tick();  // cycle 1: REQ
      bus8.ifu_req_valid = 1'b0;
      bus8.mem_req_ready = 1'b1;
      checks++;
      if ({bus8.mem_req_valid, bus8.mem_we, bus8.mem_addr} !== {1'b1, 1'b0, 32'h8000_0010}) begin
         errors++;
         $display("FAIL ifu_mem_req: got v=%b we=%b a=%h expected v=1 we=0 a=80000010",
                  bus8.mem_req_valid, bus8.mem_we, bus8.mem_addr);
      end
      tick();  // cycle 2: WAIT
      bus8.mem_req_ready = 1'b0;
      bus8.mem_rsp_valid = 1'b1;
      bus8.mem_rdata     = 32'hDEAD_BEEF;
      checks++;
      if ({bus8.mem_req_valid, bus8.ifu_rsp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL ifu_wait: got mem_req_valid=%b ifu_rsp_valid=%b expected 0 0",
                  bus8.mem_req_valid, bus8.ifu_rsp_valid);
      end
      tick();  // cycle 3: response pulse
      bus8.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.ifu_rdata}
          !== {3'b100, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL ifu_rsp: got v=%b err=%b lsu_v=%b d=%h expected v=1 err=0 lsu_v=0 d=deadbeef",
                  bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.ifu_rdata);
      end
      tick();
      checks++;
      if ({bus8.ifu_rsp_valid, bus8.ifu_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL ifu_rsp_once: got v=%b d=%h expected v=0 d=deadbeef",
                  bus8.ifu_rsp_valid, bus8.ifu_rdata);
      end
   endtask

   task automatic test_lsu_store;
      bus8.lsu_req_valid = 1'b1;
      bus8.lsu_we        = 1'b1;
      bus8.lsu_addr      = 32'h0000_0100;
      bus8.lsu_wdata     = 32'h1234_5678;
      bus8.lsu_wmask     = 4'b0011;
      #1;
      checks++;
      if ({bus8.ifu_req_ready, bus8.lsu_req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL lsu_ready: got %b expected 01", {bus8.ifu_req_ready, bus8.lsu_req_ready});
      end
      tick();
      // Scramble the LSU inputs to show the memory side comes from the holding registers.
      bus8.lsu_req_valid = 1'b0;
      bus8.lsu_we        = 1'b0;
      bus8.lsu_addr      = 32'hFFFF_FFFF;
      bus8.lsu_wdata     = 32'h0BAD_0BAD;
      bus8.lsu_wmask     = 4'b1111;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) bus8.mem_req_ready = 1'b1;
         checks++;
         if ({bus8.mem_req_valid, bus8.mem_we, bus8.mem_addr, bus8.mem_wdata, bus8.mem_wmask}
             !== {2'b11, 32'h0000_0100, 32'h1234_5678, 4'b0011}) begin
            errors++;
            $display("FAIL lsu_hold_c%0d: got v=%b we=%b a=%h d=%h m=%b expected v=1 we=1 a=00000100 d=12345678 m=0011",
                     k, bus8.mem_req_valid, bus8.mem_we, bus8.mem_addr, bus8.mem_wdata, bus8.mem_wmask);
         end
         tick();
      end
      bus8.mem_req_ready = 1'b0;
      bus8.mem_rsp_valid = 1'b1;
      bus8.mem_rdata     = 32'hCAFE_F00D;
      tick();
      bus8.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus8.lsu_rsp_valid, bus8.lsu_rsp_err, bus8.ifu_rsp_valid, bus8.lsu_rdata}
          !== {3'b100, 32'h0}) begin
         errors++;
         $display("FAIL lsu_store_rsp: got v=%b err=%b ifu_v=%b d=%h expected v=1 err=0 ifu_v=0 d=00000000",
                  bus8.lsu_rsp_valid, bus8.lsu_rsp_err, bus8.ifu_rsp_valid, bus8.lsu_rdata);
      end
      checks++;
      if (bus8.ifu_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL ifu_rdata_hold: got %h expected deadbeef", bus8.ifu_rdata);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      logic        exp_lsu;
      logic        prev_lsu;
      logic [31:0] exp_d;
      do_reset();
      bus8.lsu_we        = 1'b0;
      bus8.lsu_wmask     = 4'b0000;
      bus8.ifu_addr      = 32'h1000_0000;
      bus8.lsu_addr      = 32'h2000_0000;
      bus8.mem_req_ready = 1'b1;
      bus8.ifu_req_valid = 1'b1;
      bus8.lsu_req_valid = 1'b1;
      prev_lsu = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         exp_lsu = (i % 2 == 0);
         checks++;
         if ({bus8.ifu_req_ready, bus8.lsu_req_ready} !== (exp_lsu ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL b2b_grant%0d: got ifu/lsu ready %b expected %b", i,
                     {bus8.ifu_req_ready, bus8.lsu_req_ready}, exp_lsu ? 2'b01 : 2'b10);
         end
         if (i > 0) begin
            exp_d = 32'hA000_0000 + 32'(i - 1);
            checks++;
            if ({bus8.ifu_rsp_valid, bus8.lsu_rsp_valid, (prev_lsu ? bus8.lsu_rdata : bus8.ifu_rdata)}
                !== {(prev_lsu ? 2'b01 : 2'b10), exp_d}) begin
               errors++;
               $display("FAIL b2b_rsp%0d: got ifu_v=%b lsu_v=%b d=%h expected lsu=%b d=%h", i - 1,
                        bus8.ifu_rsp_valid, bus8.lsu_rsp_valid,
                        prev_lsu ? bus8.lsu_rdata : bus8.ifu_rdata, prev_lsu, exp_d);
            end
         end
         tick();  // REQ
         checks++;
         if ({bus8.mem_req_valid, bus8.mem_addr} !== {1'b1, (exp_lsu ? 32'h2000_0000 : 32'h1000_0000)}) begin
            errors++;
            $display("FAIL b2b_addr%0d: got v=%b a=%h expected v=1 a=%h", i, bus8.mem_req_valid,
                     bus8.mem_addr, exp_lsu ? 32'h2000_0000 : 32'h1000_0000);
         end
         tick();  // WAIT
         bus8.mem_rsp_valid = 1'b1;
         bus8.mem_rdata     = 32'hA000_0000 + 32'(i);
         tick();  // IDLE with response pulse
         bus8.mem_rsp_valid = 1'b0;
         if (i == 5) begin
            bus8.ifu_req_valid = 1'b0;
            bus8.lsu_req_valid = 1'b0;
         end
         prev_lsu = exp_lsu;
         #1;
      end
      checks++;
      if ({bus8.ifu_rsp_valid, bus8.lsu_rsp_valid, bus8.ifu_rdata} !== {2'b10, 32'hA000_0005}) begin
         errors++;
         $display("FAIL b2b_rsp5: got ifu_v=%b lsu_v=%b d=%h expected ifu_v=1 lsu_v=0 d=a0000005",
                  bus8.ifu_rsp_valid, bus8.lsu_rsp_valid, bus8.ifu_rdata);
      end
      bus8.mem_req_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      bus8.lsu_req_valid = 1'b1;
      bus8.lsu_we        = 1'b0;
      bus8.lsu_addr      = 32'h0000_0200;
      tick();  // accepted at the edge just passed
      bus8.lsu_req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         checks++;
         if ({bus8.mem_req_valid, bus8.lsu_rsp_valid, bus8.ifu_rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL tmo_wait_c%0d: got req_v=%b lsu_v=%b ifu_v=%b expected 1 0 0", k,
                     bus8.mem_req_valid, bus8.lsu_rsp_valid, bus8.ifu_rsp_valid);
         end
         tick();
      end
      checks++;
      if ({bus8.lsu_rsp_valid, bus8.lsu_rsp_err, bus8.ifu_rsp_valid, bus8.mem_req_valid, bus8.lsu_rdata}
          !== {4'b1100, 32'h0}) begin
         errors++;
         $display("FAIL tmo_rsp: got v=%b err=%b ifu_v=%b req_v=%b d=%h expected v=1 err=1 ifu_v=0 req_v=0 d=0",
                  bus8.lsu_rsp_valid, bus8.lsu_rsp_err, bus8.ifu_rsp_valid, bus8.mem_req_valid,
                  bus8.lsu_rdata);
      end
      tick();
      bus8.mem_rsp_valid = 1'b1;
      bus8.mem_rdata     = 32'h7777_7777;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 1) bus8.mem_rsp_valid = 1'b0;
         checks++;
         if ({bus8.lsu_rsp_valid, bus8.ifu_rsp_valid, bus8.mem_req_valid} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_stray_c%0d: got lsu_v=%b ifu_v=%b req_v=%b expected 0 0 0", k,
                     bus8.lsu_rsp_valid, bus8.ifu_rsp_valid, bus8.mem_req_valid);
         end
      end
   endtask

   task automatic test_reset_mid_wait;
      bus8.ifu_req_valid = 1'b1;
      bus8.ifu_addr      = 32'h0000_0300;
      tick();
      bus8.ifu_req_valid = 1'b0;
      bus8.mem_req_ready = 1'b1;
      tick();  // WAIT
      bus8.mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus8.mem_req_valid, bus8.mem_we, bus8.mem_wmask, bus8.ifu_rsp_valid, bus8.ifu_rsp_err,
           bus8.lsu_rsp_valid, bus8.lsu_rsp_err, bus8.ifu_req_ready, bus8.lsu_req_ready} !== 12'h000) begin
         errors++;
         $display("FAIL midrst_ctrl: got %b expected 0", {bus8.mem_req_valid, bus8.mem_we, bus8.mem_wmask,
                  bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.lsu_rsp_err,
                  bus8.ifu_req_ready, bus8.lsu_req_ready});
      end
      checks++;
      if ({bus8.mem_addr, bus8.mem_wdata, bus8.ifu_rdata, bus8.lsu_rdata} !== 128'h0) begin
         errors++;
         $display("FAIL midrst_data: got %h %h %h %h expected 0", bus8.mem_addr, bus8.mem_wdata,
                  bus8.ifu_rdata, bus8.lsu_rdata);
      end
      bus8.mem_rsp_valid = 1'b1;
      bus8.mem_rdata     = 32'hBAD0_BAD0;
      tick();
      rst = 1'b0;
      tick();
      bus8.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus8.ifu_rsp_valid, bus8.lsu_rsp_valid, bus8.ifu_rdata} !== {2'b00, 32'h0}) begin
         errors++;
         $display("FAIL midrst_no_rsp: got ifu_v=%b lsu_v=%b d=%h expected 0 0 0",
                  bus8.ifu_rsp_valid, bus8.lsu_rsp_valid, bus8.ifu_rdata);
      end
      bus8.ifu_req_valid = 1'b1;
      bus8.ifu_addr      = 32'h0000_0400;
      #1;
      checks++;
      if (bus8.ifu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_ready: got %b expected 1", bus8.ifu_req_ready);
      end
      tick();
      bus8.ifu_req_valid = 1'b0;
      bus8.mem_req_ready = 1'b1;
      checks++;
      if ({bus8.mem_req_valid, bus8.mem_addr} !== {1'b1, 32'h0000_0400}) begin
         errors++;
         $display("FAIL midrst_addr: got v=%b a=%h expected v=1 a=00000400",
                  bus8.mem_req_valid, bus8.mem_addr);
      end
      tick();
      bus8.mem_req_ready = 1'b0;
      bus8.mem_rsp_valid = 1'b1;
      bus8.mem_rdata     = 32'h5555_AAAA;
      tick();
      bus8.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.ifu_rdata}
          !== {3'b100, 32'h5555_AAAA}) begin
         errors++;
         $display("FAIL midrst_rsp: got v=%b err=%b lsu_v=%b d=%h expected v=1 err=0 lsu_v=0 d=5555aaaa",
                  bus8.ifu_rsp_valid, bus8.ifu_rsp_err, bus8.lsu_rsp_valid, bus8.ifu_rdata);
      end
      tick();
   endtask

   task automatic test_timeout_race;
      bus4.lsu_req_valid = 1'b1;
      bus4.lsu_we        = 1'b0;
      bus4.lsu_addr      = 32'h0000_0040;
      #1;
      checks++;
      if (bus4.lsu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL race_ready: got %b expected 1", bus4.lsu_req_ready);
      end
      tick();  // REQ, counter 0
      bus4.lsu_req_valid = 1'b0;
      bus4.mem_req_ready = 1'b1;
      tick();  // WAIT, counter 1
      bus4.mem_req_ready = 1'b0;
      tick();  // counter 2
      tick();  // counter 3: timeout cycle
      bus4.mem_rsp_valid = 1'b1;
      bus4.mem_rdata     = 32'h1357_9BDF;
      checks++;
      if (bus4.lsu_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL race_early: got lsu_v=%b expected 0", bus4.lsu_rsp_valid);
      end
      tick();
      bus4.mem_rsp_valid = 1'b0;
      checks++;
      if ({bus4.lsu_rsp_valid, bus4.lsu_rsp_err, bus4.ifu_rsp_valid, bus4.lsu_rdata}
          !== {3'b100, 32'h1357_9BDF}) begin
         errors++;
         $display("FAIL race_rsp: got v=%b err=%b ifu_v=%b d=%h expected v=1 err=0 ifu_v=0 d=13579bdf",
                  bus4.lsu_rsp_valid, bus4.lsu_rsp_err, bus4.ifu_rsp_valid, bus4.lsu_rdata);
      end
      tick();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ifu_read();
      test_lsu_store();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      test_timeout_race();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
